// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit with start/busy/done handshake.
// Optional MADD/MSUB accumulate path: define MULDIV_ACCUMULATE_EN.
module mul_div_unit #(
  parameter int DataWidth       = 32,
  parameter int MulBitsPerCycle = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 start,
  input  logic [2:0]           op,
  input  logic [DataWidth-1:0] a,
  input  logic [DataWidth-1:0] b,
  input  logic                 writeHigh,
  input  logic                 writeLow,
  input  logic [DataWidth-1:0] wData,
  output logic                 busy,
  output logic                 done,
  output logic [DataWidth-1:0] high,
  output logic [DataWidth-1:0] low
);

  localparam int W  = DataWidth;
  localparam int K  = MulBitsPerCycle;
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] MulCnt = CW'(W / K);
  localparam logic [CW-1:0] DivCnt = CW'(W);

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    ITER,
    FIXUP
  } state_e;

  state_e state_q, state_d;
  logic [2:0]     op_q, op_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   m_q, m_d;
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic pneg_q, pneg_d;
  logic rneg_q, rneg_d;
  logic dz_q, dz_d;
  logic done_q, done_d;

  logic           is_div;
  logic           sgn;
  logic           wr;
  logic           accept;
  logic [W-1:0]   abs_a;
  logic [W-1:0]   abs_b;
  logic [W+K-1:0] mul_sum;
  logic [2*W+K-1:0] mul_cat;
  logic [2*W-1:0] mul_next;
  logic [W:0]     div_rs;
  logic [W:0]     div_diff;
  logic           div_ge;
  logic [2*W-1:0] div_next;
  logic [2*W-1:0] prod;
  logic [W-1:0]   quo;
  logic [W-1:0]   rem;

  assign is_div = (op_q[2:1] == 2'b01);
  assign sgn    = ~op_q[0];
  assign wr     = writeHigh | writeLow;
  assign abs_a  = (sgn && a_q[W-1]) ? -a_q : a_q;
  assign abs_b  = (sgn && b_q[W-1]) ? -b_q : b_q;

`ifdef MULDIV_ACCUMULATE_EN
  assign accept = 1'b1;
`else
  assign accept = ~op[2];
`endif

  // acc holds {partial product high, remaining multiplier bits}
  always_comb begin
    mul_sum = {{K{1'b0}}, acc_q[2*W-1:W]};
    for (int j = 0; j < K; j++) begin
      if (acc_q[j]) begin
        mul_sum = mul_sum + ({{K{1'b0}}, m_q} << j);
      end
    end
    mul_cat  = {mul_sum, acc_q[W-1:0]};
    mul_next = (2*W)'(mul_cat >> K);
  end

  // acc holds {remainder, dividend/quotient}; rs < 2*m so bit W is the borrow
  assign div_rs   = {acc_q[2*W-1:W], acc_q[W-1]};
  assign div_diff = div_rs - {1'b0, m_q};
  assign div_ge   = ~div_diff[W];
  assign div_next = {div_ge ? div_diff[W-1:0] : div_rs[W-1:0],
                     acc_q[W-2:0], div_ge};

  assign prod = pneg_q ? -acc_q : acc_q;
  assign quo  = pneg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
  assign rem  = rneg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    pneg_d  = pneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && accept) begin
          state_d = PREP;
          op_d    = op;
          a_d     = a;
          b_d     = b;
        end
      end
      PREP: begin
        pneg_d = sgn & (a_q[W-1] ^ b_q[W-1]);
        rneg_d = sgn & a_q[W-1];
        dz_d   = is_div && (b_q == '0);
        if (is_div) begin
          m_d   = abs_b;
          acc_d = {{W{1'b0}}, abs_a};
          cnt_d = DivCnt;
        end else begin
          m_d   = abs_a;
          acc_d = {{W{1'b0}}, abs_b};
          cnt_d = MulCnt;
        end
        state_d = dz_d ? FIXUP : ITER;
      end
      ITER: begin
        acc_d = is_div ? div_next : mul_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = FIXUP;
        end
      end
      FIXUP: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (is_div) begin
          if (dz_q) begin
            {hi_d, lo_d} = {a_q, {W{1'b1}}};
          end else begin
            {hi_d, lo_d} = {rem, quo};
          end
        end else begin
`ifdef MULDIV_ACCUMULATE_EN
          if (op_q[2]) begin
            {hi_d, lo_d} = op_q[1] ? ({hi_q, lo_q} - prod)
                                   : ({hi_q, lo_q} + prod);
          end else begin
            {hi_d, lo_d} = prod;
          end
`else
          {hi_d, lo_d} = prod;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    // MTHI/MTLO always land and cancel whatever was in flight
    if (wr) begin
      state_d = IDLE;
      done_d  = 1'b0;
      hi_d    = writeHigh ? wData : hi_q;
      lo_d    = writeLow ? wData : lo_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      pneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else if (enable) begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      pneg_q  <= pneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign high = hi_q;
  assign low  = lo_q;

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative, parametrised HI/LO multiply/divide unit for the multi-cycle core generation.
- Replaces the combinational multiplier/divider pair and the separate HI/LO registers.
- Adds a start/busy/done handshake so the core stalls on MULT/DIV/MADD/MSUB and keeps its clock period independent of DataWidth.
- Owns the architectural HI and LO registers, including MTHI/MTLO writes.

Parameters:
- DataWidth, 32, operand/HI/LO width; even, >= 4.
- MulBitsPerCycle, 1, multiplier bits retired per ITER cycle; must be 1, 2 or 4 and divide DataWidth.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  global enable; low freezes every register, including done.
- start  in  1  operation request, sampled when busy=0 and enable=1.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU.
- a  in  DataWidth  rs operand (multiplicand / dividend).
- b  in  DataWidth  rt operand (multiplier / divisor).
- writeHigh  in  1  MTHI.
- writeLow  in  1  MTLO.
- wData  in  DataWidth  MTHI/MTLO data.
- busy  out  1  operation in flight; the core stalls any HI/LO consumer while high.
- done  out  1  one-cycle pulse; HI/LO hold the new result in the same cycle.
- high  out  DataWidth  HI register.
- low  out  DataWidth  LO register.

Behaviour:
- Reset (synchronous, active-high, wins over everything): state=IDLE, high=low=0, busy=0, done=0, internal datapath cleared.
- State machine: IDLE -> PREP -> ITER -> FIXUP -> IDLE.
- IDLE: start=1 latches op, a and b, and moves to PREP. busy rises on the same edge.
- PREP (1 cycle):
  - For signed ops, take absolute values and record the result sign (product: sign(a)^sign(b); quotient: sign(a)^sign(b); remainder: sign(a)).
  - DIV/DIVU with b==0 skips ITER and goes straight to FIXUP.
  - Loads counter = DataWidth/MulBitsPerCycle for multiply ops, DataWidth for divide ops.
- ITER:
  - Multiply: shift-add, MulBitsPerCycle bits per cycle into a 2*DataWidth accumulator.
  - Divide: restoring radix-2, one quotient bit per cycle.
  - Counter decrements each cycle; on the last count go to FIXUP.
- FIXUP (1 cycle):
  - Apply sign correction.
  - MADD*: {HI,LO} += product. MSUB*: {HI,LO} -= product. Both mod 2^(2*DataWidth).
  - Write HI/LO, pulse done, clear busy. HI/LO and done become visible on the same edge.
- Latency (start edge to done edge):
  - Multiply: DataWidth/MulBitsPerCycle + 2 edges (34 for 32/1).
  - Divide: DataWidth + 2 edges.
  - Divide by zero: 2 edges.
- Results:
  - Multiply: HI = upper half, LO = lower half.
  - Divide: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - Divide by zero: LO = all ones, HI = a.
  - Signed MIN / -1: LO = MIN, HI = 0 (falls out of the magnitude algorithm; no special path).
- Handshake rules:
  - start while busy=1 is ignored.
  - done is never asserted when busy=0 in the preceding cycle.
- MTHI/MTLO:
  - In IDLE, the write lands on the next edge.
  - While busy, the write lands and aborts the in-flight operation: next state IDLE, busy=0, no done.
  - writeHigh and writeLow together write both registers.
  - A write in the same cycle as start: the write lands and start is ignored.
- enable=0 mid-operation: the counter and state hold, and the operation resumes when enable returns. Total enabled-cycle latency is unchanged.
- Reset mid-operation: behaves as full reset. The operation is lost, HI/LO=0, no done.

Optional Feature:
- Macro: MULDIV_ACCUMULATE_EN.
- Defined: op 1xx (MADD/MADDU/MSUB/MSUBU) is supported as above.
- Undefined:
  - The accumulate adder/subtractor is not built.
  - start with op[2]=1 is ignored: stays IDLE, busy stays 0, no done, HI/LO unchanged.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=7, default params -> done exactly 34 edges after start edge, HI=0xFFFFFFFF, LO=0xFFFFFFEB; busy high for 34 cycles.
- DIVU a=100, b=7 -> done after 34 edges, LO=14, HI=2. DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV a=5, b=0 -> done after 2 edges, LO=0xFFFFFFFF, HI=5. DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0.
- With MULDIV_ACCUMULATE_EN: MTHI 0, MTLO 10, then MADD a=3, b=4 -> LO=22, HI=0. MSUBU a=1, b=23 from HI:LO=0:22 -> HI=0xFFFFFFFF, LO=0xFFFFFFFF. Without the macro -> busy stays 0, HI:LO unchanged.
- Abort/reset: start MULTU, then MTLO 0x55 at cycle 10 -> busy=0 next edge, LO=0x55, HI unchanged, no done. Separately, reset at cycle 10 -> HI=LO=0, busy=0, no done. start while busy -> ignored, and the first result is unaffected.
- MulBitsPerCycle=4, DataWidth=16: MULTU 0xFFFF*0xFFFF -> done after 6 edges, HI=0xFFFE, LO=0x0001. enable held low 3 cycles mid-ITER -> done after 9 edges, same result.
